// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory request arbiter: engine transaction kinds,
// arbiter states and the field widths of the load/store request types.
package mem_arbiter_pkg;

   localparam int LOAD_TYPE_W  = 3;
   localparam int STORE_TYPE_W = 2;

   localparam logic [1:0] KIND_FETCH = 2'd0;
   localparam logic [1:0] KIND_LOAD  = 2'd1;
   localparam logic [1:0] KIND_STORE = 2'd2;

   // Bit positions inside the one-hot winner vector from mem_arb_pick.
   localparam int WIN_FETCH = 0;
   localparam int WIN_LOAD  = 1;
   localparam int WIN_STORE = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

   // Address bits [17:16] == 2'b11 select the memory-mapped UART region.
   function automatic logic is_io_region(input logic [1:0] addr_17_16);
      return addr_17_16 == 2'b11;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority selector: store > load > fetch, with the fetch
// requester promoted to the top once it has been starved long enough.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic       ic_valid,
   input  logic       lb_valid,
   input  logic       sb_valid,
   input  logic       starve,
   input  logic       io_blocked,
   output logic [2:0] win
);

   always_comb begin
      win = 3'b000;
      if (ic_valid && starve) begin
         win[WIN_FETCH] = 1'b1;
      end else if (sb_valid && !io_blocked) begin
         win[WIN_STORE] = 1'b1;
      end else if (lb_valid) begin
         win[WIN_LOAD] = 1'b1;
      end else if (ic_valid) begin
         win[WIN_FETCH] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and transaction sequencer between the icache, load buffer and store
// commit path and the byte-serial memory engine; one transaction at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transaction held; choose a winner among the requesters
// ST_ISSUE | latched request offered to the engine (eng_req high)
// ST_WAIT  | engine accepted; waiting for eng_done to report completion
// ST_DRAIN | cancelled load/fetch still in the engine; swallow its eng_done
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int DEP_W        = 5
)(
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    need_flush_in,
   input  logic                    io_buffer_full,
   input  logic                    ic_valid,
   input  logic [31:0]             ic_addr,
   input  logic                    lb_valid,
   input  logic [31:0]             lb_addr,
   input  logic [LOAD_TYPE_W-1:0]  lb_load_type,
   input  logic [DEP_W-1:0]        lb_dependency,
   input  logic                    sb_valid,
   input  logic [31:0]             sb_addr,
   input  logic [31:0]             sb_data,
   input  logic [STORE_TYPE_W-1:0] sb_store_type,
   output logic                    ic_ack,
   output logic                    lb_ack,
   output logic                    sb_ack,
   output logic                    ic_done,
   output logic                    lb_done,
   output logic                    sb_done,
   output logic                    eng_req,
   input  logic                    eng_busy,
   input  logic                    eng_done,
   output logic [1:0]              eng_kind,
   output logic [31:0]             eng_addr,
   output logic [31:0]             eng_wdata,
   output logic [LOAD_TYPE_W-1:0]  eng_type,
   output logic [DEP_W-1:0]        eng_dependency,
   output logic                    busy_out
);

   localparam int              CNT_W   = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ic_ack_q, ic_ack_d;
   logic                   lb_ack_q, lb_ack_d;
   logic                   sb_ack_q, sb_ack_d;
   logic                   ic_done_q, ic_done_d;
   logic                   lb_done_q, lb_done_d;
   logic                   sb_done_q, sb_done_d;
   logic                   eng_req_q, eng_req_d;
   logic                   busy_q, busy_d;
   logic [1:0]             kind_q, kind_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [LOAD_TYPE_W-1:0] type_q, type_d;
   logic [DEP_W-1:0]       dep_q, dep_d;

   logic [2:0] win;
   logic       starve;
   logic       io_blocked;
   logic       speculative;

   assign starve      = (cnt_q >= CNT_MAX);
   assign io_blocked  = io_buffer_full && is_io_region(sb_addr[17:16]);
   assign speculative = (kind_q != KIND_STORE);

   mem_arb_pick u_pick (
      .ic_valid   (ic_valid),
      .lb_valid   (lb_valid),
      .sb_valid   (sb_valid),
      .starve     (starve),
      .io_blocked (io_blocked),
      .win        (win)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ic_ack_d  = 1'b0;
      lb_ack_d  = 1'b0;
      sb_ack_d  = 1'b0;
      ic_done_d = 1'b0;
      lb_done_d = 1'b0;
      sb_done_d = 1'b0;
      eng_req_d = eng_req_q;
      kind_d    = kind_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      type_d    = type_q;
      dep_d     = dep_q;

      if (rdy_in) begin
         if (!ic_valid) begin
            cnt_d = '0;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (win != 3'b000) begin
                  state_d   = ST_ISSUE;
                  eng_req_d = 1'b1;
                  if (win[WIN_STORE]) begin
                     kind_d   = KIND_STORE;
                     addr_d   = sb_addr;
                     wdata_d  = sb_data;
                     type_d   = LOAD_TYPE_W'(sb_store_type);
                     dep_d    = '0;
                     sb_ack_d = 1'b1;
                  end else if (win[WIN_LOAD]) begin
                     kind_d   = KIND_LOAD;
                     addr_d   = lb_addr;
                     wdata_d  = '0;
                     type_d   = lb_load_type;
                     dep_d    = lb_dependency;
                     lb_ack_d = 1'b1;
                  end else begin
                     kind_d   = KIND_FETCH;
                     addr_d   = ic_addr;
                     wdata_d  = '0;
                     type_d   = '0;
                     dep_d    = '0;
                     ic_ack_d = 1'b1;
                  end

                  // Fetch grant resets the starvation count; others age it.
                  if (win[WIN_FETCH]) begin
                     cnt_d = '0;
                  end else if (ic_valid && (cnt_q != CNT_MAX)) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            ST_ISSUE: begin
               if (need_flush_in && speculative) begin
                  state_d   = ST_IDLE;
                  eng_req_d = 1'b0;
               end else if (!eng_busy) begin
                  state_d   = ST_WAIT;
                  eng_req_d = 1'b0;
               end
            end

            ST_WAIT: begin
               if (need_flush_in && speculative) begin
                  state_d = eng_done ? ST_IDLE : ST_DRAIN;
               end else if (eng_done) begin
                  state_d   = ST_IDLE;
                  ic_done_d = (kind_q == KIND_FETCH);
                  lb_done_d = (kind_q == KIND_LOAD);
                  sb_done_d = (kind_q == KIND_STORE);
               end
            end

            ST_DRAIN: begin
               if (eng_done) begin
                  state_d = ST_IDLE;
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ic_ack_q  <= 1'b0;
         lb_ack_q  <= 1'b0;
         sb_ack_q  <= 1'b0;
         ic_done_q <= 1'b0;
         lb_done_q <= 1'b0;
         sb_done_q <= 1'b0;
         eng_req_q <= 1'b0;
         busy_q    <= 1'b0;
         kind_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         type_q    <= '0;
         dep_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ic_ack_q  <= ic_ack_d;
         lb_ack_q  <= lb_ack_d;
         sb_ack_q  <= sb_ack_d;
         ic_done_q <= ic_done_d;
         lb_done_q <= lb_done_d;
         sb_done_q <= sb_done_d;
         eng_req_q <= eng_req_d;
         busy_q    <= busy_d;
         kind_q    <= kind_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         type_q    <= type_d;
         dep_q     <= dep_d;
      end
   end

   assign ic_ack         = ic_ack_q;
   assign lb_ack         = lb_ack_q;
   assign sb_ack         = sb_ack_q;
   assign ic_done        = ic_done_q;
   assign lb_done        = lb_done_q;
   assign sb_done        = sb_done_q;
   assign eng_req        = eng_req_q;
   assign busy_out       = busy_q;
   assign eng_kind       = kind_q;
   assign eng_addr       = addr_q;
   assign eng_wdata      = wdata_q;
   assign eng_type       = type_q;
   assign eng_dependency = dep_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model of its grant order, starvation rule, flush cancellation and freeze.
module tb_mem_arbiter;

   localparam int DEP_W   = 5;
   localparam int LIMIT   = 8;
   localparam int K_NONE  = -1;
   localparam int K_FETCH = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   logic             clk_in = 1'b0;
   logic             rst_in, rdy_in, need_flush_in, io_buffer_full;
   logic             ic_valid, lb_valid, sb_valid;
   logic [31:0]      ic_addr, lb_addr, sb_addr, sb_data;
   logic [2:0]       lb_load_type;
   logic [DEP_W-1:0] lb_dependency;
   logic [1:0]       sb_store_type;
   logic             eng_busy, eng_done;
   logic             ic_ack, lb_ack, sb_ack, ic_done, lb_done, sb_done;
   logic             eng_req, busy_out;
   logic [1:0]       eng_kind;
   logic [31:0]      eng_addr, eng_wdata;
   logic [2:0]       eng_type;
   logic [DEP_W-1:0] eng_dependency;

   int errors    = 0;
   int checks    = 0;
   int model_cnt = 0;

   always #5 clk_in = ~clk_in;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .DEP_W(DEP_W)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .need_flush_in  (need_flush_in),
      .io_buffer_full (io_buffer_full),
      .ic_valid       (ic_valid),
      .ic_addr        (ic_addr),
      .lb_valid       (lb_valid),
      .lb_addr        (lb_addr),
      .lb_load_type   (lb_load_type),
      .lb_dependency  (lb_dependency),
      .sb_valid       (sb_valid),
      .sb_addr        (sb_addr),
      .sb_data        (sb_data),
      .sb_store_type  (sb_store_type),
      .ic_ack         (ic_ack),
      .lb_ack         (lb_ack),
      .sb_ack         (sb_ack),
      .ic_done        (ic_done),
      .lb_done        (lb_done),
      .sb_done        (sb_done),
      .eng_req        (eng_req),
      .eng_busy       (eng_busy),
      .eng_done       (eng_done),
      .eng_kind       (eng_kind),
      .eng_addr       (eng_addr),
      .eng_wdata      (eng_wdata),
      .eng_type       (eng_type),
      .eng_dependency (eng_dependency),
      .busy_out       (busy_out)
   );

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] acks();
      return 32'({ic_ack, lb_ack, sb_ack});
   endfunction

   function automatic logic [31:0] dones();
      return 32'({ic_done, lb_done, sb_done});
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_acks"}, acks(), 32'd0);
      check({tag, "_dones"}, dones(), 32'd0);
      check({tag, "_req"}, 32'(eng_req), 32'd0);
      check({tag, "_busy"}, 32'(busy_out), 32'd0);
      check({tag, "_kind"}, 32'(eng_kind), 32'd0);
      check({tag, "_addr"}, eng_addr, 32'd0);
      check({tag, "_wdata"}, eng_wdata, 32'd0);
      check({tag, "_type"}, 32'(eng_type), 32'd0);
      check({tag, "_dep"}, 32'(eng_dependency), 32'd0);
   endtask

   // Reference grant rule: starved fetch first, then store (unless it targets
   // the UART while its buffer is full), then load, then fetch.
   function automatic int predict();
      logic [1:0] region;
      region = sb_addr[17:16];
      if (ic_valid && model_cnt >= LIMIT) return K_FETCH;
      if (sb_valid && !(region == 2'b11 && io_buffer_full)) return K_STORE;
      if (lb_valid) return K_LOAD;
      if (ic_valid) return K_FETCH;
      return K_NONE;
   endfunction

   // Called on the cycle the ack should be visible; checks the latched fields
   // against the request that was presented, then retires that request.
   task automatic grant_check(input int k);
      check("ack_ic", acks(), (k == K_FETCH) ? 32'd4 : (k == K_LOAD) ? 32'd2 : 32'd1);
      check("grant_req", 32'(eng_req), 32'd1);
      check("grant_busy", 32'(busy_out), 32'd1);
      check("grant_dones", dones(), 32'd0);
      check("grant_kind", 32'(eng_kind), 32'(k));
      if (k == K_STORE) begin
         check("store_addr", eng_addr, sb_addr);
         check("store_wdata", eng_wdata, sb_data);
         check("store_type", 32'(eng_type), 32'(sb_store_type));
         sb_valid = 1'b0;
      end else if (k == K_LOAD) begin
         check("load_addr", eng_addr, lb_addr);
         check("load_type", 32'(eng_type), 32'(lb_load_type));
         check("load_dep", 32'(eng_dependency), 32'(lb_dependency));
         lb_valid = 1'b0;
      end else begin
         check("fetch_addr", eng_addr, ic_addr);
         ic_valid = 1'b0;
      end
      if (k == K_FETCH || !ic_valid) model_cnt = 0;
      else if (model_cnt < LIMIT) model_cnt++;
   endtask

   // Acts as the engine from the ISSUE cycle to the done cycle.
   // flush_mode: 0 none, 1 flush on the first WAIT cycle, 2 flush with eng_done.
   task automatic txn_tail(input int k, input int busy_cyc, input int lat, input int flush_mode);
      logic cancelled;
      for (int i = 0; i < busy_cyc; i++) begin
         eng_busy = 1'b1;
         step();
         check("hold_req", 32'(eng_req), 32'd1);
         check("ack_pulse", acks(), 32'd0);
      end
      eng_busy = 1'b0;
      step();
      check("req_drop", 32'(eng_req), 32'd0);
      check("wait_busy", 32'(busy_out), 32'd1);
      check("ack_pulse2", acks(), 32'd0);
      for (int i = 0; i < lat; i++) begin
         need_flush_in = (flush_mode == 1 && i == 0);
         step();
         need_flush_in = 1'b0;
         check("no_early_done", dones(), 32'd0);
         check("inflight_busy", 32'(busy_out), 32'd1);
      end
      eng_done = 1'b1;
      need_flush_in = (flush_mode == 2 || (flush_mode == 1 && lat == 0));
      step();
      eng_done = 1'b0;
      need_flush_in = 1'b0;
      cancelled = (flush_mode != 0) && (k != K_STORE);
      check("done", dones(), cancelled ? 32'd0 :
            (k == K_FETCH) ? 32'd4 : (k == K_LOAD) ? 32'd2 : 32'd1);
      check("done_idle", 32'(busy_out), 32'd0);
   endtask

   initial begin
      int k;
      int mode;
      rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0; io_buffer_full = 1'b0;
      ic_valid = 1'b0; lb_valid = 1'b0; sb_valid = 1'b0;
      ic_addr = 32'h0; lb_addr = 32'h0; sb_addr = 32'h0; sb_data = 32'h0;
      lb_load_type = 3'd0; lb_dependency = '0; sb_store_type = 2'd0;
      eng_busy = 1'b0; eng_done = 1'b0;
      step();
      step();
      check_all_zero("reset");
      rst_in = 1'b0;
      step();
      check("idle_busy", 32'(busy_out), 32'd0);

      // All three requesters at once: store, then load, then fetch.
      sb_valid = 1'b1; sb_addr = 32'h0000_1234; sb_data = 32'hDEAD_BEEF; sb_store_type = 2'd2;
      lb_valid = 1'b1; lb_addr = 32'h0000_2000; lb_load_type = 3'd4; lb_dependency = 5'd17;
      ic_valid = 1'b1; ic_addr = 32'h0000_0040;
      step(); grant_check(K_STORE); txn_tail(K_STORE, 1, 2, 0);
      step(); grant_check(K_LOAD);  txn_tail(K_LOAD, 0, 1, 0);
      step(); grant_check(K_FETCH); txn_tail(K_FETCH, 0, 0, 0);

      // Starvation: eight loads while the fetch waits, then the fetch wins.
      ic_valid = 1'b1; ic_addr = 32'h0000_0080;
      for (int i = 0; i < 8; i++) begin
         lb_valid = 1'b1; lb_addr = 32'h100 + 32'(i * 4);
         lb_load_type = 3'(i); lb_dependency = 5'(i + 3);
         step(); grant_check(K_LOAD); txn_tail(K_LOAD, 0, 1, 0);
      end
      lb_valid = 1'b1; lb_addr = 32'h0000_0500;
      step(); grant_check(K_FETCH); txn_tail(K_FETCH, 0, 1, 0);
      ic_valid = 1'b1; ic_addr = 32'h0000_00C0;
      step(); grant_check(K_LOAD);  txn_tail(K_LOAD, 0, 1, 0);
      step(); grant_check(K_FETCH); txn_tail(K_FETCH, 0, 1, 0);

      // UART store blocked by a full buffer; the load goes first.
      io_buffer_full = 1'b1;
      sb_valid = 1'b1; sb_addr = 32'h0003_0000; sb_data = 32'h0000_0041; sb_store_type = 2'd0;
      lb_valid = 1'b1; lb_addr = 32'h0000_3000; lb_load_type = 3'd2; lb_dependency = 5'd9;
      step(); grant_check(K_LOAD); txn_tail(K_LOAD, 0, 2, 0);
      step(); check("io_block_ack", acks(), 32'd0);
      step(); check("io_block_ack2", acks(), 32'd0);
      check("io_block_busy", 32'(busy_out), 32'd0);
      io_buffer_full = 1'b0;
      step(); grant_check(K_STORE); txn_tail(K_STORE, 0, 1, 0);

      // Flush cancels a load in WAIT; its completion is drained silently.
      lb_valid = 1'b1; lb_addr = 32'h0000_4000; lb_load_type = 3'd1; lb_dependency = 5'd2;
      step(); grant_check(K_LOAD); txn_tail(K_LOAD, 0, 4, 1);

      // A committed store ignores flush in both ISSUE and WAIT.
      sb_valid = 1'b1; sb_addr = 32'h0000_5000; sb_data = 32'h1234_5678; sb_store_type = 2'd1;
      step(); grant_check(K_STORE);
      eng_busy = 1'b1; need_flush_in = 1'b1;
      step();
      need_flush_in = 1'b0;
      check("store_issue_flush_req", 32'(eng_req), 32'd1);
      check("store_issue_flush_busy", 32'(busy_out), 32'd1);
      txn_tail(K_STORE, 0, 2, 1);

      // Flush in IDLE is ignored; flush in ISSUE drops the load.
      lb_valid = 1'b1; lb_addr = 32'h0000_6000; lb_load_type = 3'd5; lb_dependency = 5'd30;
      need_flush_in = 1'b1;
      step(); grant_check(K_LOAD);
      step();
      need_flush_in = 1'b0;
      check("issue_flush_req", 32'(eng_req), 32'd0);
      check("issue_flush_busy", 32'(busy_out), 32'd0);
      step();
      check("issue_flush_nodone", dones(), 32'd0);

      // Flush together with eng_done for a fetch: straight to idle, no done.
      ic_valid = 1'b1; ic_addr = 32'h0000_0100;
      step(); grant_check(K_FETCH); txn_tail(K_FETCH, 1, 1, 2);

      // Freeze in ISSUE, then eng_done ignored while frozen in WAIT, then reset.
      lb_valid = 1'b1; lb_addr = 32'h0000_7000; lb_load_type = 3'd3; lb_dependency = 5'd5;
      eng_busy = 1'b1;
      step(); grant_check(K_LOAD);
      step();
      rdy_in = 1'b0; eng_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("freeze_req", 32'(eng_req), 32'd1);
         check("freeze_busy", 32'(busy_out), 32'd1);
      end
      rdy_in = 1'b1;
      step();
      check("thaw_wait_req", 32'(eng_req), 32'd0);
      check("thaw_wait_busy", 32'(busy_out), 32'd1);
      rdy_in = 1'b0; eng_done = 1'b1;
      step();
      rdy_in = 1'b1; eng_done = 1'b0;
      step();
      check("frozen_done_ignored", dones(), 32'd0);
      check("frozen_done_busy", 32'(busy_out), 32'd1);
      rst_in = 1'b1; eng_done = 1'b1; need_flush_in = 1'b1;
      step();
      rst_in = 1'b0; eng_done = 1'b0; need_flush_in = 1'b0;
      check_all_zero("reset_wait");
      model_cnt = 0;
      step();
      check("post_reset_dones", dones(), 32'd0);
      check("post_reset_busy", 32'(busy_out), 32'd0);

      // Randomized traffic against the reference grant rule.
      for (int t = 0; t < 60; t++) begin
         if (!ic_valid && ($urandom % 3 == 0)) begin
            ic_valid = 1'b1; ic_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!lb_valid && ($urandom % 2 == 0)) begin
            lb_valid = 1'b1; lb_addr = $urandom;
            lb_load_type = 3'($urandom); lb_dependency = DEP_W'($urandom);
         end
         if (!sb_valid && ($urandom % 2 == 0)) begin
            sb_valid = 1'b1;
            sb_addr = ($urandom & 32'hFFFC_FFFF) | (($urandom % 2 == 0) ? 32'h0003_0000 : 32'h0);
            sb_data = $urandom; sb_store_type = 2'($urandom);
         end
         if (!ic_valid && !lb_valid && !sb_valid) begin
            lb_valid = 1'b1; lb_addr = $urandom;
            lb_load_type = 3'($urandom); lb_dependency = DEP_W'($urandom);
         end
         io_buffer_full = ($urandom % 3 == 0);
         k = predict();
         if (k == K_NONE) begin
            step();
            check("rand_blocked_noack", acks(), 32'd0);
            io_buffer_full = 1'b0;
            k = predict();
         end
         step();
         grant_check(k);
         mode = int'($urandom % 4);
         if (mode == 3) mode = 0;
         txn_tail(k, int'($urandom % 3), int'($urandom % 4), mode);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
